// File: rtl/tx_scheduler_pkg.sv
// tx_sched_pkg: shared state encoding, word geometry and byte selection for tx_scheduler
package tx_sched_pkg;
    typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_SEND = 1'b1} state_e;
    localparam logic [0:0] IDLE = ST_IDLE;
    localparam logic [0:0] SEND = ST_SEND;
    localparam int BYTES_PER_WORD = 4;
    localparam int LEN_W = 2;
    function automatic logic [7:0] byte_sel(input logic [31:0] word, input logic [LEN_W-1:0] idx);
        return 8'(word >> {idx, 3'b000});
    endfunction
endpackage

// File: rtl/tx_scheduler_if.sv
// tx_scheduler_if: producer request bus and UART byte handshake
interface tx_scheduler_if #(parameter int NREQ = 2);
    logic [NREQ-1:0]    req_valid;
    logic [NREQ*32-1:0] req_data;
    logic [NREQ*2-1:0]  req_len;
    logic [NREQ-1:0]    req_ready;
    logic [7:0]         tx_data;
    logic               tx_valid;
    logic               tx_ready;
    modport master (output req_valid, req_data, req_len, tx_ready, input req_ready, tx_data, tx_valid);
    modport slave (input req_valid, req_data, req_len, tx_ready, output req_ready, tx_data, tx_valid);
endinterface

// File: rtl/tx_scheduler_rr_arbiter.sv
// rr_arbiter: one-hot round-robin grant, searching upward from the requester after last
module rr_arbiter #(parameter int NREQ = 2) (
    input  logic [NREQ-1:0] req,
    input  logic [2:0]      last,
    input  logic            en,
    output logic [NREQ-1:0] grant
);
    localparam int IW = $clog2(NREQ);
    logic [IW-1:0] pos;
    always_comb begin
        grant = '0;
        pos = '0;
        for (int k = NREQ; k >= 1; k--) begin
            pos = IW'((int'(last) + k) % NREQ);
            if (en && req[pos]) begin
                grant = '0;
                grant[pos] = 1'b1;
            end
        end
    end
endmodule

// File: rtl/tx_scheduler.sv
// tx_scheduler: round-robin word arbiter streaming the granted word MSB-first as bytes
module tx_scheduler
    import tx_sched_pkg::*;
#(
    parameter int NREQ  = 2,
    parameter int CNT_W = 16
) (
    input  logic             CLK,
    input  logic             reset,
    tx_scheduler_if.slave    bus,
    output logic             busy,
    output logic [2:0]       grant_id,
    output logic [CNT_W-1:0] sent_words
);
    logic [0:0]       state;
    logic [2:0]       last;
    logic [31:0]      word;
    logic [LEN_W-1:0] idx;
    logic [NREQ-1:0]  grant;
    logic [2:0]       win;
    logic [31:0]      win_data;
    logic [LEN_W-1:0] win_len;
    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .req   (bus.req_valid),
        .last  (last),
        .en    ((state == IDLE) && reset),
        .grant (grant)
    );
    always_comb begin
        win = '0;
        win_data = '0;
        win_len = '0;
        for (int i = 0; i < NREQ; i++)
            if (grant[i]) begin
                win = 3'(i);
                win_data = bus.req_data[32*i +: 32];
                win_len = bus.req_len[2*i +: 2];
            end
    end
    assign bus.req_ready = grant;
    assign bus.tx_valid  = (state == SEND);
    assign bus.tx_data   = (state == SEND) ? byte_sel(word, idx) : 8'h00;
    assign busy          = (state == SEND);
    always_ff @(posedge CLK) begin
        if (!reset) begin
            state      <= IDLE;
            last       <= 3'(NREQ - 1);
            word       <= '0;
            idx        <= '0;
            grant_id   <= '0;
            sent_words <= '0;
        end else if (state == IDLE) begin
            if (|grant) begin
                word     <= win_data;
                idx      <= win_len;
                last     <= win;
                grant_id <= win;
                state    <= SEND;
            end
        end else if (bus.tx_ready) begin
            if (idx != '0) idx <= idx - 1'b1;
            else begin
                sent_words <= sent_words + 1'b1;
                state      <= IDLE;
            end
        end
    end
endmodule
